// File: rtl/fade_ctrl.sv
// fade_ctrl: brightness sequencer for the PWM/ramp datapath.
// Accepts set / fade / breathe / stop commands and steps the output level
// by one count per prescaled step tick. The tick period is 2^rate clocks.
module fade_ctrl #(
    parameter int PRESCALE_W = 16,
    parameter int HOLD_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_target,
    input  logic [3:0] cmd_rate,
    output logic [7:0] level,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        FADE,
        BR_UP,
        BR_HOLD_TOP,
        BR_DOWN,
        BR_HOLD_BOT
    } state_t;

    localparam logic [1:0] MODE_SET     = 2'b00;
    localparam logic [1:0] MODE_FADE    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    // A hold of 0 or 1 both leave the extreme on the first tick spent there.
    localparam int HOLD_W      = (HOLD_STEPS < 2) ? 1 : $clog2(HOLD_STEPS);
    localparam int HOLD_LAST_I = (HOLD_STEPS < 1) ? 0 : HOLD_STEPS - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];

    state_t                  state;
    logic [7:0]              target_q;
    logic [3:0]              rate_q;
    logic [PRESCALE_W-1:0]   presc;
    logic [PRESCALE_W-1:0]   presc_last;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    accept;
    logic                    tick;
    logic [7:0]              fade_next;
    logic [7:0]              up_next;
    logic [7:0]              dn_next;

    // Rates beyond the prescaler width collapse to the slowest usable rate.
    function automatic logic [3:0] sat_rate(input logic [3:0] r);
        if (int'(r) >= PRESCALE_W) begin
            sat_rate = 4'(PRESCALE_W - 1);
        end else begin
            sat_rate = r;
        end
    endfunction

    // Single-count moves that pin at the ends of the 8-bit range.
    function automatic logic [7:0] step_up(input logic [7:0] l);
        step_up = (l == 8'hFF) ? l : l + 8'd1;
    endfunction

    function automatic logic [7:0] step_dn(input logic [7:0] l);
        step_dn = (l == 8'h00) ? l : l - 8'd1;
    endfunction

    function automatic logic [7:0] step_toward(input logic [7:0] l, input logic [7:0] t);
        step_toward = (t > l) ? step_up(l) : step_dn(l);
    endfunction

    assign cmd_ready  = (state != FADE);
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign presc_last = ~({PRESCALE_W{1'b1}} << rate_q);
    assign tick       = (presc == presc_last);
    assign fade_next  = step_toward(level, target_q);
    assign up_next    = step_up(level);
    assign dn_next    = step_dn(level);

    // Step prescaler: restarts on every accepted command and on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (accept || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Command decode and level sequencing; a new command overrides any tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            level    <= 8'd0;
            target_q <= 8'd0;
            rate_q   <= 4'd0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                target_q <= cmd_target;
                rate_q   <= sat_rate(cmd_rate);
                hold_cnt <= '0;
                case (cmd_mode)
                    MODE_SET: begin
                        level <= cmd_target;
                        state <= IDLE;
                    end
                    MODE_FADE: begin
                        state <= FADE;
                    end
                    MODE_BREATHE: begin
                        if (cmd_target == 8'd0) begin
                            level <= 8'd0;
                            state <= IDLE;
                        end else if (level < cmd_target) begin
                            state <= BR_UP;
                        end else begin
                            state <= BR_DOWN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else begin
                case (state)
                    FADE: begin
                        if (level == target_q) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else if (tick) begin
                            level <= fade_next;
                            if (fade_next == target_q) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    BR_UP: begin
                        if (tick) begin
                            level <= up_next;
                            if (up_next == target_q) begin
                                state <= BR_HOLD_TOP;
                            end
                        end
                    end
                    BR_HOLD_TOP: begin
                        if (tick) begin
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= '0;
                                state    <= BR_DOWN;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    BR_DOWN: begin
                        if (tick) begin
                            level <= dn_next;
                            if (dn_next == 8'd0) begin
                                state <= BR_HOLD_BOT;
                            end
                        end
                    end
                    BR_HOLD_BOT: begin
                        if (tick) begin
                            if (hold_cnt == HOLD_LAST) begin
                                hold_cnt <= '0;
                                state    <= BR_UP;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fade_ctrl.sv
// Testbench for fade_ctrl: directed sequences, a vector table and random
// commands, all cross-checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_fade_ctrl;

    localparam int PRESCALE_W = 16;
    localparam int HOLD_STEPS = 2;

    localparam logic [1:0] M_SET     = 2'd0;
    localparam logic [1:0] M_FADE    = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;
    localparam logic [1:0] M_STOP    = 2'd3;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       cmd_valid  = 1'b0;
    logic [1:0] cmd_mode   = 2'd0;
    logic [7:0] cmd_target = 8'd0;
    logic [3:0] cmd_rate   = 4'd0;
    logic       cmd_ready;
    logic [7:0] level;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    fade_ctrl #(
        .PRESCALE_W (PRESCALE_W),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .level      (level),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: activity kind, clocks since accept, direction and dwell.
    localparam int K_IDLE    = 0;
    localparam int K_FADE    = 1;
    localparam int K_BREATHE = 2;

    int m_level = 0, m_tgt = 0, m_rate = 0, m_cyc = 0;
    int m_kind = K_IDLE, m_dir = 0, m_dwell = 0, m_hold = 1;
    bit m_done = 1'b0;
    bit m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = 0; m_tgt = 0; m_rate = 0; m_cyc = 0;
            m_kind = K_IDLE; m_dir = 0; m_dwell = 0; m_done = 1'b0;
        end else begin
            m_hold = (HOLD_STEPS > 0) ? HOLD_STEPS : 1;
            m_done = 1'b0;
            if (cmd_valid && m_kind != K_FADE) begin
                m_tgt   = cmd_target;
                m_rate  = (cmd_rate >= PRESCALE_W) ? PRESCALE_W - 1 : cmd_rate;
                m_cyc   = 0;
                m_dwell = 0;
                case (cmd_mode)
                    M_SET:  begin m_level = cmd_target; m_kind = K_IDLE; end
                    M_FADE: m_kind = K_FADE;
                    M_BREATHE: begin
                        if (cmd_target == 0) begin
                            m_level = 0; m_kind = K_IDLE;
                        end else begin
                            m_kind = K_BREATHE;
                            m_dir  = (m_level < m_tgt) ? 1 : -1;
                        end
                    end
                    default: m_kind = K_IDLE;
                endcase
            end else begin
                m_tick = ((m_cyc + 1) % (1 << m_rate)) == 0;
                m_cyc  = m_cyc + 1;
                if (m_kind == K_FADE) begin
                    if (m_level == m_tgt) begin
                        m_kind = K_IDLE; m_done = 1'b1;
                    end else if (m_tick) begin
                        m_level = m_level + ((m_tgt > m_level) ? 1 : -1);
                        if (m_level == m_tgt) begin
                            m_kind = K_IDLE; m_done = 1'b1;
                        end
                    end
                end else if (m_kind == K_BREATHE && m_tick) begin
                    if (m_dwell > 0) begin
                        m_dwell = m_dwell - 1;
                    end else begin
                        m_level = m_level + m_dir;
                        if (m_dir > 0 && m_level == m_tgt) begin
                            m_dir = -1; m_dwell = m_hold;
                        end else if (m_dir < 0 && m_level == 0) begin
                            m_dir = 1; m_dwell = m_hold;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_model();
        check("model level", int'(level), m_level);
        check("model busy", int'(busy), (m_kind != K_IDLE) ? 1 : 0);
        check("model done", int'(done), int'(m_done));
        check("model cmd_ready", int'(cmd_ready), (m_kind != K_FADE) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic send(input logic [1:0] mode, input logic [7:0] tgt, input logic [3:0] rate);
        cmd_mode   = mode;
        cmd_target = tgt;
        cmd_rate   = rate;
        cmd_valid  = 1'b1;
        cycle();
        cmd_valid  = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] target;
        logic [3:0] rate;
        int         wait_cyc;
        int         exp_level;
        int         exp_busy;
    } vec_t;

    vec_t vecs[14];
    int   br_pat[10];

    initial begin
        vecs[0]  = '{M_SET,     8'd50,  4'd0, 0,   50,  0};
        vecs[1]  = '{M_FADE,    8'd53,  4'd0, 3,   53,  0};
        vecs[2]  = '{M_FADE,    8'd50,  4'd1, 6,   50,  0};
        vecs[3]  = '{M_STOP,    8'd9,   4'd0, 1,   50,  0};
        vecs[4]  = '{M_BREATHE, 8'd0,   4'd0, 0,   0,   0};
        vecs[5]  = '{M_BREATHE, 8'd4,   4'd0, 4,   4,   1};
        vecs[6]  = '{M_STOP,    8'd0,   4'd0, 0,   4,   0};
        vecs[7]  = '{M_SET,     8'd255, 4'd0, 0,   255, 0};
        vecs[8]  = '{M_BREATHE, 8'd10,  4'd0, 3,   252, 1};
        vecs[9]  = '{M_SET,     8'd0,   4'd0, 0,   0,   0};
        vecs[10] = '{M_FADE,    8'd255, 4'd0, 255, 255, 0};
        vecs[11] = '{M_FADE,    8'd0,   4'd0, 255, 0,   0};
        vecs[12] = '{M_BREATHE, 8'd1,   4'd0, 4,   0,   1};
        vecs[13] = '{M_STOP,    8'd0,   4'd0, 0,   0,   0};
        br_pat   = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0};

        // Reset state
        @(posedge clk);
        #1;
        check("reset level", int'(level), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fade 0 -> 8 at one step per clock
        send(M_FADE, 8'd8, 4'd0);
        check("fade8 accept level", int'(level), 0);
        check("fade8 accept busy", int'(busy), 1);
        check("fade8 accept ready", int'(cmd_ready), 0);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check("fade8 level", int'(level), i);
            check("fade8 done", int'(done), (i == 8) ? 1 : 0);
            check("fade8 busy", int'(busy), (i < 8) ? 1 : 0);
        end
        cycle();
        check("fade8 done one cycle", int'(done), 0);

        // Fade 8 -> 5 at rate 2 with a competing command held during FADE
        send(M_FADE, 8'd5, 4'd2);
        cmd_mode   = M_SET;
        cmd_target = 8'd0;
        cmd_rate   = 4'd0;
        for (int c = 1; c <= 12; c++) begin
            cmd_valid = (c < 12);
            cycle();
            check("fade5 level", int'(level), 8 - c / 4);
            check("fade5 done", int'(done), (c == 12) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        cycle();
        check("fade5 after level", int'(level), 5);
        check("fade5 after done", int'(done), 0);

        // Set 200 then fade to the same level
        send(M_SET, 8'd200, 4'd0);
        check("set200 level", int'(level), 200);
        check("set200 done", int'(done), 0);
        check("set200 busy", int'(busy), 0);
        send(M_FADE, 8'd200, 4'd0);
        check("fade200 accept busy", int'(busy), 1);
        cycle();
        check("fade200 level", int'(level), 200);
        check("fade200 done", int'(done), 1);
        check("fade200 busy", int'(busy), 0);
        cycle();
        check("fade200 done clears", int'(done), 0);

        // Breathe 0..3 with hold 2, then stop
        send(M_SET, 8'd0, 4'd0);
        send(M_BREATHE, 8'd3, 4'd0);
        for (int i = 0; i < 22; i++) begin
            cycle();
            check("breathe level", int'(level), br_pat[i % 10]);
            check("breathe done", int'(done), 0);
            check("breathe busy", int'(busy), 1);
        end
        send(M_STOP, 8'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("stop level", int'(level), br_pat[21 % 10]);
            check("stop busy", int'(busy), 0);
            cycle();
        end

        // Fade issued mid-breathe at level 2
        send(M_BREATHE, 8'd3, 4'd0);
        repeat (4) cycle();
        check("mid-breathe level", int'(level), 2);
        send(M_FADE, 8'd0, 4'd0);
        check("br-fade accept level", int'(level), 2);
        check("br-fade accept ready", int'(cmd_ready), 0);
        cycle();
        check("br-fade level1", int'(level), 1);
        cycle();
        check("br-fade level0", int'(level), 0);
        check("br-fade done", int'(done), 1);

        // Vector table
        for (int v = 0; v < 14; v++) begin
            send(vecs[v].mode, vecs[v].target, vecs[v].rate);
            repeat (vecs[v].wait_cyc) cycle();
            check($sformatf("vec%0d level", v), int'(level), vecs[v].exp_level);
            check($sformatf("vec%0d busy", v), int'(busy), vecs[v].exp_busy);
        end

        // Reset in the middle of a fade
        send(M_SET, 8'd0, 4'd0);
        send(M_FADE, 8'd200, 4'd0);
        repeat (100) cycle();
        check("pre-reset level", int'(level), 100);
        rst_n = 1'b0;
        #1;
        check("async reset level", int'(level), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset done", int'(done), 0);
        compare_model();
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post-reset level", int'(level), 0);
            check("post-reset done", int'(done), 0);
            check("post-reset busy", int'(busy), 0);
        end

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(0, 7) == 0);
            cmd_mode   = 2'($urandom_range(0, 3));
            cmd_target = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 12));
            cmd_rate   = 4'($urandom_range(0, 2));
            cycle();
        end
        cmd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
